mac_rx: RTL
===========

MAC_RX -- requirements
Module: mac_rx

Interface
REQ-001 parameter mac_my_adr, default 48'he86a64fad17b, station MAC; frames to it or to ff:ff:ff:ff:ff:ff are accepted.
REQ-002 parameter ip_my_adr, default {8'd192,8'd168,8'd15,8'd14}, required IPv4 destination.
REQ-003 parameter udp_my_port, default 16'd11451, required UDP destination port.
REQ-004 I_clk50m  in  1  RMII reference clock; the block's only clock.
REQ-005 I_rst  in  1  reset, asynchronous, active-high.
REQ-006 I_rxd  in  2  RMII receive dibit, LSB-first within each byte.
REQ-007 I_crsdv  in  1  RMII carrier-sense/data-valid.
REQ-008 O_data  out  8  payload byte.
REQ-009 O_valid  out  1  O_data is valid this cycle.
REQ-010 O_sop / O_eop  out  1 each  first / last payload byte, qualified by O_valid.
REQ-011 O_dataLen  out  16  payload length, equal to UDP length minus 8; valid from the O_sop cycle until the next frame starts.
REQ-012 O_srcIp  out  32  sender IPv4 address; O_srcPort  out  16  sender UDP port; both valid from O_sop.
REQ-013 O_done  out  1  one-cycle pulse at the end of every accepted frame.
REQ-014 O_crcOk  out  1  FCS result; valid in the O_done cycle.
REQ-015 O_busy  out  1  high in every state except IDLE.

Function
REQ-016 Dibit assembler: one byte completes every 4 cycles, with dibits placed at bits [1:0], [3:2], [5:4], [7:6] in that order; byte-strobe alignment resets at SFD.
REQ-017 FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, TAIL, DROP.
REQ-018 IDLE -> PREAMBLE when I_crsdv=1 and I_rxd=2'b01.
REQ-019 PREAMBLE -> HEADER on dibit 2'b11 after at least 8 consecutive 2'b01; any other dibit -> IDLE.
REQ-020 HEADER captures 42 bytes: dst MAC, src MAC, ethertype, 20-byte IPv4 header, 8-byte UDP header.
REQ-021 HEADER -> DROP if the dst MAC matches neither accepted address, ethertype != 16'h0800, IP version/IHL != 8'h45, protocol != 8'd17, dst IP != ip_my_adr, dst port != udp_my_port, or UDP length < 8.
REQ-022 Each DROP check is evaluated on the byte that completes its field.
REQ-023 HEADER -> PAYLOAD after byte 42, or -> TAIL directly when UDP length = 8; O_sop is asserted on the first payload byte.
REQ-024 O_valid is registered, one cycle after the byte-strobe, and pulses once per byte (never on consecutive cycles).
REQ-025 PAYLOAD counts bytes; the byte numbered O_dataLen carries O_eop; state -> TAIL.
REQ-026 TAIL consumes padding and FCS until end-of-frame.
REQ-027 End-of-frame is I_crsdv low for 2 consecutive cycles; a single-cycle low is ignored (RMII CRS_DV toggling).
REQ-028 CRC-32 (poly 0x04C11DB7, reflected, init 32'hFFFFFFFF) runs over every byte from dst MAC through FCS.
REQ-029 O_crcOk=1 only if the residue equals 32'hC704DD7B and the total byte count >= 64.
REQ-030 At end-of-frame in TAIL: O_done pulses for 1 cycle; state -> IDLE.
REQ-031 End-of-frame during HEADER or PAYLOAD: O_done pulses with O_crcOk=0; O_eop is not generated; state -> IDLE.
REQ-032 DROP waits for end-of-frame and returns to IDLE with no O_done and no O_valid.
REQ-033 Frames longer than 1522 bytes -> DROP; a frame already past O_sop follows REQ-031 instead.
REQ-034 All counters are 16-bit and never wrap within an accepted frame.

Reset
REQ-035 Asserting I_rst forces IDLE immediately, including mid-frame.
REQ-036 Reset values: O_valid, O_sop, O_eop, O_done, O_crcOk, O_busy = 0; O_data, O_dataLen, O_srcIp, O_srcPort = 0; CRC register = 32'hFFFFFFFF.
REQ-037 After reset release, reception resumes only at the next preamble.

Structure
REQ-038 Package eth_pkg holds the state enum, ETH_TYPE_IPV4, IP_PROTO_UDP, CRC_POLY, CRC_RESIDUE, HDR_BYTES=42 and MIN_FRAME=64.
REQ-039 Sub-module crc32_d8: one byte per enable, with init and value ports; shared with the transmitter.

Verification
REQ-040 Valid frame, 100-byte payload of 8'haa, correct FCS -> 100 O_valid pulses, O_sop on byte 1, O_eop on byte 100, O_dataLen=100, O_done with O_crcOk=1.
REQ-041 Same frame with one payload bit flipped -> all 100 bytes delivered, O_crcOk=0.
REQ-042 dst port 16'd1234 -> no O_valid and no O_done; O_busy drops after end-of-frame.
REQ-043 10-byte payload padded to 64 bytes -> 10 bytes out, O_eop on byte 10, O_crcOk=1.
REQ-044 I_rst asserted at payload byte 50 of 1200 -> all outputs 0 next cycle; the following valid frame is received correctly.
REQ-045 Single-cycle I_crsdv drop mid-payload -> no truncation; a 2-cycle drop -> O_done with O_crcOk=0 and no O_eop.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet/IPv4/UDP constants, receiver state encoding and the byte-wise CRC-32 step
// shared by the receive and transmit paths.
package eth_pkg;
   typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TAIL, DROP} rx_state_t;
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0] IP_VER_IHL = 8'h45;
   localparam logic [7:0] IP_PROTO_UDP = 8'd17;
   localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   localparam logic [15:0] HDR_BYTES = 16'd42;
   localparam logic [15:0] MIN_FRAME = 16'd64;
   localparam logic [15:0] MAX_FRAME = 16'd1522;
   localparam logic [15:0] UDP_HDR = 16'd8;
   localparam logic [3:0] PRE_MIN = 4'd8;
   // Register is kept MSB-first while bits enter LSB-first, so the good-frame residue reads 0xC704DD7B.
   function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'd0);
      return r;
   endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: Ethernet CRC-32 accumulator advancing one byte per enable.
module crc32_d8
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] value
);
   always_ff @(posedge clk or posedge rst)
      if (rst) value <= CRC_INIT;
      else if (init) value <= CRC_INIT;
      else if (en) value <= crc32_step(value, data);
endmodule

// File: rtl/mac_rx.sv
// mac_rx: RMII receiver that accepts IPv4/UDP frames addressed to this station
// and streams the UDP payload with per-frame length, sender address and FCS status.
module mac_rx
   import eth_pkg::*;
#(
   parameter logic [47:0] mac_my_adr  = 48'he86a64fad17b,
   parameter logic [31:0] ip_my_adr   = {8'd192, 8'd168, 8'd15, 8'd14},
   parameter logic [15:0] udp_my_port = 16'd11451
) (
   input  logic        I_clk50m,
   input  logic        I_rst,
   input  logic [1:0]  I_rxd,
   input  logic        I_crsdv,
   output logic [7:0]  O_data,
   output logic        O_valid,
   output logic        O_sop,
   output logic        O_eop,
   output logic [15:0] O_dataLen,
   output logic [31:0] O_srcIp,
   output logic [15:0] O_srcPort,
   output logic        O_done,
   output logic        O_crcOk,
   output logic        O_busy
);
   rx_state_t st;
   logic [5:0] sh;
   logic [1:0] phase;
   logic [3:0] pre_cnt;
   logic [15:0] bcnt, pcnt;
   logic [39:0] sr;
   logic [31:0] crc;
   logic [7:0] cur;
   logic [47:0] f48;
   logic [31:0] f32;
   logic [15:0] f16;
   logic was_low, eof, sfd, strobe;
   // cur is the byte completed by this cycle's dibit; f* are header fields ending in cur
   assign cur = {I_rxd, sh};
   assign f48 = {sr, cur};
   assign f32 = f48[31:0];
   assign f16 = f48[15:0];
   assign eof = !I_crsdv && was_low;
   assign sfd = st == PREAMBLE && I_rxd == 2'b11 && pre_cnt >= PRE_MIN;
   assign strobe = st inside {HEADER, PAYLOAD, TAIL} && phase == 2'd3;
   assign O_busy = st != IDLE;
   crc32_d8 u_crc (.clk(I_clk50m), .rst(I_rst), .init(sfd), .en(strobe), .data(cur), .value(crc));
   always_ff @(posedge I_clk50m or posedge I_rst)
      if (I_rst) begin
         st <= IDLE;
         sh <= '0;
         phase <= '0;
         pre_cnt <= '0;
         bcnt <= '0;
         pcnt <= '0;
         sr <= '0;
         was_low <= 1'b0;
         O_data <= '0;
         O_valid <= 1'b0;
         O_sop <= 1'b0;
         O_eop <= 1'b0;
         O_done <= 1'b0;
         O_crcOk <= 1'b0;
         O_dataLen <= '0;
         O_srcIp <= '0;
         O_srcPort <= '0;
      end else begin
         sh <= cur[7:2];
         phase <= sfd ? 2'd0 : phase + 2'd1;
         was_low <= !I_crsdv;
         O_valid <= 1'b0;
         O_sop <= 1'b0;
         O_eop <= 1'b0;
         O_done <= 1'b0;
         case (st)
            IDLE: if (I_crsdv && I_rxd == 2'b01) begin
               st <= PREAMBLE;
               pre_cnt <= 4'd1;
            end
            PREAMBLE:
               if (sfd) begin
                  st <= HEADER;
                  bcnt <= '0;
                  pcnt <= '0;
               end else if (I_rxd == 2'b01) pre_cnt <= (pre_cnt == PRE_MIN) ? pre_cnt : pre_cnt + 4'd1;
               else st <= IDLE;
            DROP: if (eof) st <= IDLE;
            HEADER, PAYLOAD, TAIL:
               if (eof) begin
                  st <= IDLE;
                  O_done <= 1'b1;
                  O_crcOk <= st == TAIL && crc == CRC_RESIDUE && bcnt >= MIN_FRAME;
               end else if (strobe) begin
                  bcnt <= bcnt + 16'd1;
                  sr <= f48[39:0];
                  // oversize: once payload has started, end it like a truncated frame
                  if (bcnt == MAX_FRAME) begin
                     st <= (st == HEADER || O_dataLen == '0) ? DROP : IDLE;
                     O_done <= st != HEADER && O_dataLen != '0;
                     O_crcOk <= 1'b0;
                  end else if (st == HEADER)
                     case (bcnt)
                        16'd5: if (f48 != mac_my_adr && f48 != '1) st <= DROP;
                        16'd13: if (f16 != ETH_TYPE_IPV4) st <= DROP;
                        16'd14: if (cur != IP_VER_IHL) st <= DROP;
                        16'd23: if (cur != IP_PROTO_UDP) st <= DROP;
                        16'd29: O_srcIp <= f32;
                        16'd33: if (f32 != ip_my_adr) st <= DROP;
                        16'd35: O_srcPort <= f16;
                        16'd37: if (f16 != udp_my_port) st <= DROP;
                        16'd39: if (f16 < UDP_HDR) st <= DROP; else O_dataLen <= f16 - UDP_HDR;
                        HDR_BYTES - 16'd1: st <= (O_dataLen == '0) ? TAIL : PAYLOAD;
                        default: ;
                     endcase
                  else if (st == PAYLOAD) begin
                     O_data <= cur;
                     O_valid <= 1'b1;
                     O_sop <= pcnt == '0;
                     O_eop <= pcnt + 16'd1 == O_dataLen;
                     pcnt <= pcnt + 16'd1;
                     if (pcnt + 16'd1 == O_dataLen) st <= TAIL;
                  end
               end
            default: st <= IDLE;
         endcase
      end
endmodule
